regfile_write_port: RTL and testbench



---
 rtl/regfile_pkg.sv | 29 ++
 rtl/regfile_write_port_dff.sv | 31 +++
 rtl/regfile_write_port.sv | 114 +++++++++++
 tb/tb_regfile_write_port.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared types and constants for the 8-entry register file write side.
//   WIDTH      : default data width of every architectural register
//   NUM_REGS   : number of architectural registers (reg0..reg7)
//   regidx_t   : 3-bit register index
//   wr_entry_t : one queued write request {num, data}
//   onehot()   : decode of a register index into an 8-bit mask
// ---------------------------------------------------------------------------
package regfile_pkg;

   localparam int WIDTH    = 16;
   localparam int NUM_REGS = 8;

   typedef logic [2:0] regidx_t;

   typedef struct packed {
      regidx_t            num;
      logic [WIDTH-1:0]   data;
   } wr_entry_t;

   function automatic logic [NUM_REGS-1:0] onehot(input regidx_t idx);
      logic [NUM_REGS-1:0] mask;
      mask      = '0;
      mask[idx] = 1'b1;
      return mask;
   endfunction

endpackage

// File: rtl/regfile_write_port_dff.sv
// ---------------------------------------------------------------------------
// DFlipFlopAllow
// Enabled D register with asynchronous active-low clear; one instance holds
// one architectural register.
//   clk   : clock
//   rst_n : asynchronous active-low clear to zero
//   allow : load enable; q takes d on the rising edge while high
//   d     : data to load
//   q     : registered contents
// ---------------------------------------------------------------------------
module DFlipFlopAllow #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             allow,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // NOTE: state is written with non-blocking assignments so every flop
   // samples the pre-edge value of its inputs, independent of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (allow) begin
         q <= d;
      end
   end

endmodule

// File: rtl/regfile_write_port.sv
// ---------------------------------------------------------------------------
// regfile_write_port
// Write side of the 8 x WIDTH register file. Write requests arrive over a
// valid/ready handshake, are buffered in a 2-entry in-order queue, and at
// most one queued entry commits per cycle into reg0..reg7. A pending mask
// flags registers with queued, uncommitted writes for hazard detection.
//   clk, rst_n     : clock, asynchronous active-low reset
//   write_valid    : write request present
//   write_ready    : queue can accept a request this cycle
//   writenum       : destination register index
//   data_in        : write data
//   hold           : read side busy, blocks commits while high
//   commit_valid   : head entry is written at the end of this cycle
//   commit_num     : index being committed (valid with commit_valid)
//   pending        : bit i set while any queued entry targets register i
//   reg0..reg7     : architectural register contents
// ---------------------------------------------------------------------------
module regfile_write_port #(
   parameter int WIDTH = regfile_pkg::WIDTH,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             write_valid,
   output logic             write_ready,
   input  logic [2:0]       writenum,
   input  logic [WIDTH-1:0] data_in,
   input  logic             hold,
   output logic             commit_valid,
   output logic [2:0]       commit_num,
   output logic [7:0]       pending,
   output logic [WIDTH-1:0] reg0,
   output logic [WIDTH-1:0] reg1,
   output logic [WIDTH-1:0] reg2,
   output logic [WIDTH-1:0] reg3,
   output logic [WIDTH-1:0] reg4,
   output logic [WIDTH-1:0] reg5,
   output logic [WIDTH-1:0] reg6,
   output logic [WIDTH-1:0] reg7
);

   import regfile_pkg::*;

   // Queue state: 1-bit pointers suffice for the 2-entry queue.
   logic [1:0]       count;
   logic             head;
   logic             tail;
   regidx_t          q_num  [2];
   logic [WIDTH-1:0] q_data [2];

   logic             accept;
   logic [WIDTH-1:0] regs [NUM_REGS];

   // Ready depends only on registered state and reset, never on hold.
   assign write_ready  = (count < 2'(DEPTH)) && rst_n;
   assign accept       = write_valid && write_ready;
   assign commit_valid = (count != 2'd0) && !hold;
   assign commit_num   = q_num[head];

   // Head entry is valid with one or more queued; the other slot only when full.
   always_comb begin
      pending = '0;
      if (count != 2'd0) pending = pending | onehot(q_num[head]);
      if (count == 2'd2) pending = pending | onehot(q_num[~head]);
   end

   // NOTE: the queue payload has no reset; count gates every use of it,
   // so clearing the storage would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (accept) begin
         q_num[tail]  <= writenum;
         q_data[tail] <= data_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 2'd0;
         head  <= 1'b0;
         tail  <= 1'b0;
      end else begin
         if (accept)       tail <= ~tail;
         if (commit_valid) head <= ~head;
         // Simultaneous accept and commit leaves the count unchanged.
         case ({accept, commit_valid})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      DFlipFlopAllow #(
         .WIDTH (WIDTH)
      ) u_reg (
         .clk   (clk),
         .rst_n (rst_n),
         .allow (commit_valid && (commit_num == regidx_t'(i))),
         .d     (q_data[head]),
         .q     (regs[i])
      );
   end

   assign reg0 = regs[0];
   assign reg1 = regs[1];
   assign reg2 = regs[2];
   assign reg3 = regs[3];
   assign reg4 = regs[4];
   assign reg5 = regs[5];
   assign reg6 = regs[6];
   assign reg7 = regs[7];

endmodule

// File: tb/tb_regfile_write_port.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_port
// Directed bench for regfile_write_port. Inputs change 1 ns after the
// rising edge and outputs are sampled there, away from the active edge.
// ---------------------------------------------------------------------------
module tb_regfile_write_port;

   localparam int W = 16;

   logic         clk;
   logic         rst_n;
   logic         write_valid;
   logic         write_ready;
   logic [2:0]   writenum;
   logic [W-1:0] data_in;
   logic         hold;
   logic         commit_valid;
   logic [2:0]   commit_num;
   logic [7:0]   pending;
   logic [W-1:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7;
   logic [W-1:0] regs [8];

   int passed;
   int total;

   regfile_write_port #(
      .WIDTH (W),
      .DEPTH (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .write_valid  (write_valid),
      .write_ready  (write_ready),
      .writenum     (writenum),
      .data_in      (data_in),
      .hold         (hold),
      .commit_valid (commit_valid),
      .commit_num   (commit_num),
      .pending      (pending),
      .reg0         (reg0),
      .reg1         (reg1),
      .reg2         (reg2),
      .reg3         (reg3),
      .reg4         (reg4),
      .reg5         (reg5),
      .reg6         (reg6),
      .reg7         (reg7)
   );

   assign regs[0] = reg0;
   assign regs[1] = reg1;
   assign regs[2] = reg2;
   assign regs[3] = reg3;
   assign regs[4] = reg4;
   assign regs[5] = reg5;
   assign regs[6] = reg6;
   assign regs[7] = reg7;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      write_valid = 1'b0;
      writenum    = '0;
      data_in     = '0;
      hold        = 1'b0;
      #12;
      total++;
      if (write_ready !== 1'b0) $display("FAIL reset_ready_low got=%b exp=0", write_ready);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         total++;
         if (regs[i] !== 16'h0000) $display("FAIL reset_reg%0d got=%h exp=0000", i, regs[i]);
         else passed++;
      end
      total++;
      if (pending !== 8'h00) $display("FAIL reset_pending got=%h exp=00", pending);
      else passed++;
      total++;
      if (commit_valid !== 1'b0) $display("FAIL reset_commit_valid got=%b exp=0", commit_valid);
      else passed++;
      total++;
      if (write_ready !== 1'b1) $display("FAIL reset_ready_high got=%b exp=1", write_ready);
      else passed++;
   endtask

   task automatic test_single_write();
      write_valid = 1'b1;
      writenum    = 3'd3;
      data_in     = 16'hBEEF;
      tick();
      write_valid = 1'b0;
      total++;
      if (pending !== 8'h08) $display("FAIL single_pending got=%h exp=08", pending);
      else passed++;
      total++;
      if (commit_valid !== 1'b1 || commit_num !== 3'd3)
         $display("FAIL single_commit got=%b/%0d exp=1/3", commit_valid, commit_num);
      else passed++;
      total++;
      if (reg3 !== 16'h0000) $display("FAIL single_no_bypass got=%h exp=0000", reg3);
      else passed++;
      tick();
      total++;
      if (reg3 !== 16'hBEEF) $display("FAIL single_reg3 got=%h exp=beef", reg3);
      else passed++;
      total++;
      if (pending !== 8'h00) $display("FAIL single_pending_clear got=%h exp=00", pending);
      else passed++;
      for (int i = 0; i < 8; i++) begin
         if (i != 3) begin
            total++;
            if (regs[i] !== 16'h0000) $display("FAIL single_other_reg%0d got=%h exp=0000", i, regs[i]);
            else passed++;
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         write_valid = 1'b1;
         writenum    = 3'(i);
         data_in     = 16'h1000 + 16'(i);
         total++;
         if (write_ready !== 1'b1) $display("FAIL b2b_ready_%0d got=%b exp=1", i, write_ready);
         else passed++;
         tick();
         if (i > 0) begin
            total++;
            if (regs[i-1] !== 16'h1000 + 16'(i-1))
               $display("FAIL b2b_reg%0d got=%h exp=%h", i-1, regs[i-1], 16'h1000 + 16'(i-1));
            else passed++;
         end
      end
      write_valid = 1'b0;
      tick();
      total++;
      if (reg7 !== 16'h1007) $display("FAIL b2b_reg7 got=%h exp=1007", reg7);
      else passed++;
      total++;
      if (pending !== 8'h00) $display("FAIL b2b_pending got=%h exp=00", pending);
      else passed++;
   endtask

   task automatic test_hold_full();
      hold        = 1'b1;
      write_valid = 1'b1;
      writenum    = 3'd5;
      data_in     = 16'h0005;
      tick();
      data_in     = 16'h0055;
      tick();
      write_valid = 1'b0;
      total++;
      if (write_ready !== 1'b0) $display("FAIL hold_ready_full got=%b exp=0", write_ready);
      else passed++;
      total++;
      if (pending !== 8'h20) $display("FAIL hold_pending got=%h exp=20", pending);
      else passed++;
      total++;
      if (commit_valid !== 1'b0) $display("FAIL hold_commit_valid got=%b exp=0", commit_valid);
      else passed++;
      tick();
      total++;
      if (reg5 !== 16'h1005) $display("FAIL hold_reg5_stable got=%h exp=1005", reg5);
      else passed++;
      hold = 1'b0;
      tick();
      total++;
      if (reg5 !== 16'h0005) $display("FAIL hold_reg5_first got=%h exp=0005", reg5);
      else passed++;
      total++;
      if (write_ready !== 1'b1) $display("FAIL hold_ready_back got=%b exp=1", write_ready);
      else passed++;
      total++;
      if (pending !== 8'h20) $display("FAIL hold_pending_second got=%h exp=20", pending);
      else passed++;
      tick();
      total++;
      if (reg5 !== 16'h0055) $display("FAIL hold_reg5_second got=%h exp=0055", reg5);
      else passed++;
      total++;
      if (pending !== 8'h00) $display("FAIL hold_pending_clear got=%h exp=00", pending);
      else passed++;
   endtask

   task automatic test_simultaneous();
      write_valid = 1'b1;
      writenum    = 3'd2;
      data_in     = 16'hAAAA;
      tick();
      // count is 1: next edge both accepts and commits
      data_in = 16'hBBBB;
      total++;
      if (write_ready !== 1'b1 || commit_valid !== 1'b1)
         $display("FAIL simul_handshake got=%b/%b exp=1/1", write_ready, commit_valid);
      else passed++;
      tick();
      writenum = 3'd6;
      data_in  = 16'h6666;
      total++;
      if (reg2 !== 16'hAAAA) $display("FAIL simul_reg2_first got=%h exp=aaaa", reg2);
      else passed++;
      total++;
      if (pending !== 8'h04 || write_ready !== 1'b1)
         $display("FAIL simul_count_one got=%h/%b exp=04/1", pending, write_ready);
      else passed++;
      tick();
      write_valid = 1'b0;
      total++;
      if (reg2 !== 16'hBBBB) $display("FAIL simul_reg2_second got=%h exp=bbbb", reg2);
      else passed++;
      total++;
      if (pending !== 8'h40) $display("FAIL simul_pending6 got=%h exp=40", pending);
      else passed++;
      tick();
      total++;
      if (reg6 !== 16'h6666) $display("FAIL simul_reg6 got=%h exp=6666", reg6);
      else passed++;
      total++;
      if (commit_valid !== 1'b0) $display("FAIL simul_drained got=%b exp=0", commit_valid);
      else passed++;
   endtask

   task automatic test_reset_mid();
      hold        = 1'b1;
      write_valid = 1'b1;
      writenum    = 3'd1;
      data_in     = 16'h1111;
      tick();
      writenum    = 3'd4;
      data_in     = 16'h4444;
      tick();
      write_valid = 1'b0;
      total++;
      if (pending !== 8'h12 || write_ready !== 1'b0)
         $display("FAIL midrst_full got=%h/%b exp=12/0", pending, write_ready);
      else passed++;
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (pending !== 8'h00) $display("FAIL midrst_pending got=%h exp=00", pending);
      else passed++;
      total++;
      if (write_ready !== 1'b0 || commit_valid !== 1'b0)
         $display("FAIL midrst_ready_commit got=%b/%b exp=0/0", write_ready, commit_valid);
      else passed++;
      for (int i = 0; i < 8; i++) begin
         total++;
         if (regs[i] !== 16'h0000) $display("FAIL midrst_reg%0d got=%h exp=0000", i, regs[i]);
         else passed++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      hold  = 1'b0;
      tick();
      tick();
      tick();
      total++;
      if (reg1 !== 16'h0000 || reg4 !== 16'h0000)
         $display("FAIL midrst_discarded got=%h/%h exp=0000/0000", reg1, reg4);
      else passed++;
      total++;
      if (write_ready !== 1'b1 || pending !== 8'h00)
         $display("FAIL midrst_after got=%b/%h exp=1/00", write_ready, pending);
      else passed++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      passed = 0;
      total  = 0;
      test_reset();
      test_single_write();
      test_back_to_back();
      test_hold_full();
      test_simultaneous();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
